sw_debounce: RTL and testbench

//   Debounces and synchronises raw board switch/key inputs ahead of the switch
//   PIO slave. debounced_out drives the PIO in_port directly, so the PIO's

---
 rtl/sw_debounce.sv | 58 +++++
 tb/tb_sw_debounce.sv | 117 +++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-channel stability counter for raw switch inputs.
// A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module sw_debounce #(
  parameter int WIDTH           = 4,
  parameter int CNT_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     s1;
  logic [WIDTH-1:0]     s2;
  logic [CNT_WIDTH-1:0] cnt [WIDTH];
  logic [WIDTH-1:0]     accept;

  // A channel flips on the edge where its differing sample has been seen D times.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (s2[i] != debounced_out[i]) && (cnt[i] == CNT_TERM);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1            <= '0;
      s2            <= '0;
      debounced_out <= '0;
      rise_pulse    <= '0;
      fall_pulse    <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= raw_in;
      s2 <= s1;
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == debounced_out[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
      debounced_out <= debounced_out ^ accept;
      rise_pulse    <= accept & s2;
      fall_pulse    <= accept & ~s2;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with D=8: hand-computed output/pulse
// expectations checked one clock edge at a time.
module tb_sw_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] raw_in;
  logic [3:0] debounced_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;

  int checks   = 0;
  int failures = 0;

  sw_debounce #(
    .WIDTH(4),
    .CNT_WIDTH(16),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_in(raw_in),
    .debounced_out(debounced_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  // One clock edge, then compare all three outputs 1 ns later.
  task automatic step_chk(input string tag, input logic [3:0] e_out,
                          input logic [3:0] e_rise, input logic [3:0] e_fall);
    @(posedge clk);
    #1;
    checks++;
    assert (debounced_out === e_out) else begin
      failures++;
      $error("FAIL %s out observed=%b expected=%b", tag, debounced_out, e_out);
    end
    checks++;
    assert (rise_pulse === e_rise) else begin
      failures++;
      $error("FAIL %s rise observed=%b expected=%b", tag, rise_pulse, e_rise);
    end
    checks++;
    assert (fall_pulse === e_fall) else begin
      failures++;
      $error("FAIL %s fall observed=%b expected=%b", tag, fall_pulse, e_fall);
    end
  endtask

  // Input was just changed: 9 quiet edges, update + pulse on the 10th, pulse gone on the 11th.
  task automatic settle(input string tag, input logic [3:0] out_old, input logic [3:0] out_new,
                        input logic [3:0] e_rise, input logic [3:0] e_fall);
    for (int i = 0; i < 9; i++) step_chk({tag, "_wait"}, out_old, 4'b0000, 4'b0000);
    step_chk({tag, "_upd"}, out_new, e_rise, e_fall);
    step_chk({tag, "_after"}, out_new, 4'b0000, 4'b0000);
  endtask

  initial begin
    reset  = 1'b1;
    raw_in = 4'b0000;
    step_chk("reset0", 4'b0000, 4'b0000, 4'b0000);
    step_chk("reset1", 4'b0000, 4'b0000, 4'b0000);

    // Clean rise on bit 0, then fall back
    reset  = 1'b0;
    raw_in = 4'b0001;
    settle("clean_rise", 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    raw_in = 4'b0000;
    settle("clean_fall", 4'b0001, 4'b0000, 4'b0000, 4'b0001);

    // Bounce: 5 high, 3 low, then held high
    raw_in = 4'b0001;
    for (int i = 0; i < 5; i++) step_chk("bounce_hi", 4'b0000, 4'b0000, 4'b0000);
    raw_in = 4'b0000;
    for (int i = 0; i < 3; i++) step_chk("bounce_lo", 4'b0000, 4'b0000, 4'b0000);
    raw_in = 4'b0001;
    settle("bounce_hold", 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    for (int i = 0; i < 5; i++) step_chk("bounce_tail", 4'b0001, 4'b0000, 4'b0000);

    // Single-cycle glitch on bit 2
    raw_in = 4'b0101;
    step_chk("glitch_on", 4'b0001, 4'b0000, 4'b0000);
    raw_in = 4'b0001;
    for (int i = 0; i < 20; i++) step_chk("glitch", 4'b0001, 4'b0000, 4'b0000);

    // Bring all high, then simultaneous 1111 -> 0110
    raw_in = 4'b1111;
    settle("all_high", 4'b0001, 4'b1111, 4'b1110, 4'b0000);
    raw_in = 4'b0110;
    settle("simul", 4'b1111, 4'b0110, 4'b0000, 4'b1001);

    // Clear, then reset while cnt[3] == 5
    reset  = 1'b1;
    raw_in = 4'b0000;
    step_chk("clear_rst", 4'b0000, 4'b0000, 4'b0000);
    reset  = 1'b0;
    raw_in = 4'b1000;
    for (int i = 0; i < 7; i++) step_chk("pre_rst", 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b1;
    step_chk("mid_rst", 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
    settle("post_rst", 4'b0000, 4'b1000, 4'b1000, 4'b0000);

    // Fall after rise on bit 1
    raw_in = 4'b1010;
    settle("b1_rise", 4'b1000, 4'b1010, 4'b0010, 4'b0000);
    raw_in = 4'b1000;
    settle("b1_fall", 4'b1010, 4'b1000, 4'b0000, 4'b0010);
    for (int i = 0; i < 4; i++) step_chk("b1_tail", 4'b1000, 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
